// File: rtl/sd_spi_pkg.sv
// Shared types and defaults for the SD-card SPI byte initiator.
package sd_spi_pkg;

  localparam int SD_DIV_W    = 8;
  localparam int SD_SLOW_DIV = 31;
  localparam int SD_FAST_DIV = 0;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    FINISH
  } state_t;

  // Picks the half-period reload value for a byte from the fast/slow request.
  function automatic logic [SD_DIV_W-1:0] pick_div(input logic fast,
                                                   input int fast_div,
                                                   input int slow_div);
    return fast ? SD_DIV_W'(fast_div) : SD_DIV_W'(slow_div);
  endfunction

endpackage

// File: rtl/spi_half_div.sv
// Loadable half-period counter: counts 0..div inclusive and pulses tick on div.
module spi_half_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = run && (cnt == div);

  // The counter clears itself on tick, so it never wraps past div.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/sd_spi_host.sv
// SPI mode-0 byte initiator for an SD card, driven by a start/done handshake.
module sd_spi_host
  import sd_spi_pkg::*;
#(
  parameter int SLOW_DIV = SD_SLOW_DIV,
  parameter int FAST_DIV = SD_FAST_DIV,
  parameter int DIV_W    = SD_DIV_W
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       fast,
  input  logic       cs_assert,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sd_sck,
  output logic       sd_mosi,
  output logic       sd_cs_n,
  input  logic       sd_miso
);

  state_t state, state_next;

  logic [DIV_W-1:0] div_q, div_next;
  logic [7:0]       tx_shift, tx_shift_next;
  logic [7:0]       rx_shift, rx_shift_next;
  logic [2:0]       bit_cnt, bit_cnt_next;
  logic [7:0]       rx_data_next;
  logic             busy_next, done_next;
  logic             sck_next, mosi_next, cs_n_next;
  logic             div_load, div_run, tick;

  assign div_load = (state == IDLE);
  assign div_run  = (state == LOW) || (state == HIGH);

  spi_half_div #(
    .DIV_W(DIV_W)
  ) u_half_div (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .load   (div_load),
    .run    (div_run),
    .div    (div_q),
    .tick   (tick)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = LOW;
      LOW:     if (tick) state_next = HIGH;
      HIGH:    if (tick) state_next = (bit_cnt == 3'd7) ? FINISH : LOW;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values for every datapath and pin register; all outputs come from flops.
  always_comb begin
    div_next      = div_q;
    tx_shift_next = tx_shift;
    rx_shift_next = rx_shift;
    bit_cnt_next  = bit_cnt;
    rx_data_next  = rx_data;
    busy_next     = busy;
    done_next     = 1'b0;
    sck_next      = sd_sck;
    mosi_next     = sd_mosi;
    cs_n_next     = sd_cs_n;
    unique case (state)
      IDLE: begin
        cs_n_next = ~cs_assert;
        if (start) begin
          tx_shift_next = tx_data;
          div_next      = pick_div(fast, FAST_DIV, SLOW_DIV);
          mosi_next     = tx_data[7];
          bit_cnt_next  = 3'd0;
          busy_next     = 1'b1;
        end
      end
      LOW: begin
        if (tick) begin
          sck_next      = 1'b1;
          rx_shift_next = {rx_shift[6:0], sd_miso};
        end
      end
      HIGH: begin
        if (tick) begin
          sck_next = 1'b0;
          if (bit_cnt != 3'd7) begin
            bit_cnt_next  = bit_cnt + 3'd1;
            tx_shift_next = {tx_shift[6:0], 1'b0};
            mosi_next     = tx_shift[6];
          end
        end
      end
      FINISH: begin
        mosi_next    = 1'b1;
        rx_data_next = rx_shift;
        done_next    = 1'b1;
        busy_next    = 1'b0;
      end
      default: begin
        sck_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      tx_shift <= 8'h00;
      rx_shift <= 8'h00;
      bit_cnt  <= 3'd0;
      rx_data  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      sd_sck   <= 1'b0;
      sd_mosi  <= 1'b1;
      sd_cs_n  <= 1'b1;
    end else begin
      div_q    <= div_next;
      tx_shift <= tx_shift_next;
      rx_shift <= rx_shift_next;
      bit_cnt  <= bit_cnt_next;
      rx_data  <= rx_data_next;
      busy     <= busy_next;
      done     <= done_next;
      sd_sck   <= sck_next;
      sd_mosi  <= mosi_next;
      sd_cs_n  <= cs_n_next;
    end
  end

endmodule

// File: tb/tb_sd_spi_host.sv
// Self-checking bench for sd_spi_host: vector table, hand sequences, random bytes.
module tb_sd_spi_host;

  localparam int SLOW = 31;
  localparam int FAST = 0;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] tx_data;
  logic       fast;
  logic       cs_assert;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic       sd_sck;
  logic       sd_mosi;
  logic       sd_cs_n;
  logic       sd_miso;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_sys = ~clk_sys;

  sd_spi_host #(
    .SLOW_DIV(SLOW),
    .FAST_DIV(FAST),
    .DIV_W   (8)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .start    (start),
    .tx_data  (tx_data),
    .fast     (fast),
    .cs_assert(cs_assert),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data),
    .sd_sck   (sd_sck),
    .sd_mosi  (sd_mosi),
    .sd_cs_n  (sd_cs_n),
    .sd_miso  (sd_miso)
  );

  typedef struct {
    logic [7:0] tx;
    logic [7:0] miso;
    logic       fast;
    logic       cs;
    int         spur;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
    int         exp_done;
    logic       exp_cs_n;
  } vec_t;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a byte lasts 16 half-periods of (div+1) clocks plus one cycle to finish.
  function automatic int model_done(input logic f);
    int div;
    div = f ? FAST : SLOW;
    return 16 * (div + 1) + 1;
  endfunction

  // Runs one byte from posedge+1 phase; returns at posedge+1 of the done cycle.
  task automatic apply_stimulus(input logic [7:0] tx, input logic [7:0] miso, input logic f,
                                input logic cs, input int spur, input int cs_drop,
                                input logic [7:0] exp_rx, input logic [7:0] exp_mosi,
                                input int exp_done, input logic exp_cs_n, input string tag);
    int div = f ? FAST : SLOW;
    int limit = exp_done + 40;
    logic [7:0] mosi_seen = 8'h00;
    int rises = 0;
    int trans = 0;
    int last = 0;
    int bad_half = 0;
    int bad_cs = 0;
    int bad_busy = 0;
    int done_at = -1;
    logic prev_sck;
    tx_data = tx;
    fast = f;
    cs_assert = cs;
    sd_miso = miso[7];
    start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    check_output({tag, "_busy_rise"}, 32'(busy), 32'd1);
    if (sd_cs_n !== exp_cs_n) bad_cs++;
    prev_sck = sd_sck;
    for (int n = 1; n <= limit; n++) begin
      if (n == spur) begin
        start = 1'b1;
        tx_data = 8'h00;
        fast = ~f;
      end
      if (n == spur + 1) start = 1'b0;
      if (n == cs_drop) cs_assert = 1'b0;
      @(posedge clk_sys); #1;
      if (sd_sck !== prev_sck) begin
        if (n - last != div + 1) bad_half++;
        last = n;
        trans++;
        if (sd_sck) begin
          mosi_seen = {mosi_seen[6:0], sd_mosi};
          rises++;
          if (rises < 8) sd_miso = miso[7 - rises];
        end
      end
      prev_sck = sd_sck;
      if (sd_cs_n !== exp_cs_n) bad_cs++;
      if (done === 1'b1) begin
        done_at = n;
        break;
      end
      if (busy !== 1'b1) bad_busy++;
    end
    start = 1'b0;
    check_output({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
    check_output({tag, "_rx_data"}, 32'(rx_data), 32'(exp_rx));
    check_output({tag, "_mosi_bits"}, 32'(mosi_seen), 32'(exp_mosi));
    check_output({tag, "_sck_edges"}, 32'(trans), 32'd16);
    check_output({tag, "_half_period_errs"}, 32'(bad_half), 32'd0);
    check_output({tag, "_cs_errs"}, 32'(bad_cs), 32'd0);
    check_output({tag, "_busy_errs"}, 32'(bad_busy), 32'd0);
    check_output({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check_output({tag, "_mosi_idle"}, 32'(sd_mosi), 32'd1);
  endtask

  // Idles n cycles: no done may appear and rx_data must hold.
  task automatic idle_cycles(input int n, input logic [7:0] exp_rx, input string tag);
    int dones = 0;
    repeat (n) begin
      @(posedge clk_sys); #1;
      if (done === 1'b1) dones++;
    end
    check_output({tag, "_stray_done"}, 32'(dones), 32'd0);
    check_output({tag, "_rx_held"}, 32'(rx_data), 32'(exp_rx));
  endtask

  initial begin
    vec_t vecs[5];
    int rises;
    logic prev;
    reset_n = 1'b0;
    start = 1'b1;
    tx_data = 8'h00;
    fast = 1'b0;
    cs_assert = 1'b1;
    sd_miso = 1'b1;

    repeat (3) @(posedge clk_sys);
    #1;
    check_output("reset_sck", 32'(sd_sck), 32'd0);
    check_output("reset_mosi", 32'(sd_mosi), 32'd1);
    check_output("reset_cs_n", 32'(sd_cs_n), 32'd1);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_rx", 32'(rx_data), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    start = 1'b0;
    @(posedge clk_sys); #1;
    check_output("idle_cs_n", 32'(sd_cs_n), 32'd0);

    vecs[0] = '{8'hA5, 8'h3C, 1'b1, 1'b1, 0,   8'h3C, 8'hA5, 17,  1'b0};
    vecs[1] = '{8'hFF, 8'h00, 1'b0, 1'b1, 0,   8'h00, 8'hFF, 513, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 1'b1, 1'b0, 0,   8'hFF, 8'h00, 17,  1'b1};
    vecs[3] = '{8'h81, 8'h7E, 1'b1, 1'b1, 6,   8'h7E, 8'h81, 17,  1'b0};
    vecs[4] = '{8'h5A, 8'hC3, 1'b0, 1'b1, 100, 8'hC3, 8'h5A, 513, 1'b0};
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].tx, vecs[i].miso, vecs[i].fast, vecs[i].cs, vecs[i].spur, 0,
                     vecs[i].exp_rx, vecs[i].exp_mosi, vecs[i].exp_done, vecs[i].exp_cs_n,
                     $sformatf("vec%0d", i));
      idle_cycles(4, vecs[i].exp_rx, $sformatf("vec%0d", i));
    end

    // Back-to-back with cs dropped mid-byte: cs_n stays low through done, rises on next accept.
    cs_assert = 1'b1;
    @(posedge clk_sys); #1;
    apply_stimulus(8'h96, 8'h69, 1'b1, 1'b1, 0, 5, 8'h69, 8'h96, 17, 1'b0, "b2b_a");
    check_output("b2b_cs_at_done", 32'(sd_cs_n), 32'd0);
    apply_stimulus(8'h3E, 8'hE3, 1'b1, 1'b0, 0, 0, 8'hE3, 8'h3E, 17, 1'b1, "b2b_b");
    idle_cycles(3, 8'hE3, "b2b");

    // Abort mid-byte with async reset after bit 4 is sampled.
    tx_data = 8'hC3;
    fast = 1'b0;
    cs_assert = 1'b1;
    sd_miso = 1'b1;
    start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    rises = 0;
    prev = sd_sck;
    for (int n = 0; n < 2000 && rises < 5; n++) begin
      @(posedge clk_sys); #1;
      if (sd_sck && !prev) rises++;
      prev = sd_sck;
    end
    check_output("abort_reached_bit4", 32'(rises), 32'd5);
    reset_n = 1'b0;
    #1;
    check_output("abort_sck", 32'(sd_sck), 32'd0);
    check_output("abort_mosi", 32'(sd_mosi), 32'd1);
    check_output("abort_cs_n", 32'(sd_cs_n), 32'd1);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
    idle_cycles(600, 8'h00, "abort");
    apply_stimulus(8'h4D, 8'hB2, 1'b1, 1'b1, 0, 0, 8'hB2, 8'h4D, 17, 1'b0, "post_abort");
    idle_cycles(2, 8'hB2, "post_abort");

    // Random bytes against the arithmetic model, some back-to-back.
    for (int i = 0; i < 14; i++) begin
      logic [7:0] rtx;
      logic [7:0] rmiso;
      logic       rf;
      logic       rcs;
      rtx = 8'($urandom);
      rmiso = 8'($urandom);
      rf = ($urandom_range(0, 3) != 0);
      rcs = 1'($urandom);
      apply_stimulus(rtx, rmiso, rf, rcs, 0, 0, rmiso, rtx, model_done(rf), ~rcs,
                     $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 0) idle_cycles($urandom_range(1, 5), rmiso, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
